board_mem_arbiter: RTL

Owns the single-port 6x6 board RAM. Shares it between three requesters: the map loader (writes), the game engine (read-modify-write to mark hits), and the BFS sink checker (read-only).
Sequences a full-board clear and keeps a live count of unhit ship cells, which drives mem_empty for the engine.
Sits between game_engine, the BFS block, the map loader and the board RAM macro.

---
 rtl/board_pkg.sv | 42 ++++
 rtl/board_rr_arb.sv | 43 ++++
 rtl/board_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared constants, encodings and address helpers for the 6x6 board RAM
// and everything that talks to it.
package board_pkg;

    localparam int WIDTH   = 6;
    localparam int HEIGHT  = 6;
    localparam int ADDR_W  = 6;
    localparam int CNT_W   = 6;
    localparam int COORD_W = 3;
    localparam int CELLS   = WIDTH * HEIGHT;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [CNT_W-1:0]  CELLS_CNT = CNT_W'(CELLS);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    typedef enum logic [1:0] {
        REQ_INIT = 2'd0,
        REQ_ENG  = 2'd1,
        REQ_BFS  = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CLEAR   = 2'd3
    } arb_state_e;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(x) * ADDR_W'(WIDTH) + ADDR_W'(y);
    endfunction

    function automatic logic cell_in_range(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
        return (x < COORD_W'(WIDTH)) && (y < COORD_W'(HEIGHT));
    endfunction

endpackage

// File: rtl/board_rr_arb.sv
// Two-way round-robin between the game engine and the BFS checker.
// rr_last only advances on a cycle where the parent actually issues a grant.
module board_rr_arb
    import board_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic eng_req_i,
    input  logic bfs_req_i,
    input  logic en_i,
    output logic eng_win_o,
    output logic bfs_win_o
);

    req_id_e rr_last_q;

    // Pick a winner; on a tie the requester that did not win last time goes.
    always_comb begin
        eng_win_o = 1'b0;
        bfs_win_o = 1'b0;
        if (eng_req_i && bfs_req_i) begin
            eng_win_o = (rr_last_q != REQ_ENG);
            bfs_win_o = (rr_last_q == REQ_ENG);
        end else begin
            eng_win_o = eng_req_i;
            bfs_win_o = bfs_req_i;
        end
    end

    // Remember the last winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_last_q <= REQ_ENG;
        end else if (en_i && eng_win_o) begin
            rr_last_q <= REQ_ENG;
        end else if (en_i && bfs_win_o) begin
            rr_last_q <= REQ_BFS;
        end else begin
            rr_last_q <= rr_last_q;
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Owns the single-port board RAM: loader writes, engine read-modify-write,
// BFS reads, full-board clear sweep and the live count of unhit ship cells.
module board_mem_arbiter
    import board_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               init_req,
    input  logic [COORD_W-1:0] init_x,
    input  logic [COORD_W-1:0] init_y,
    input  logic [1:0]         init_data,
    output logic               init_gnt,
    input  logic               eng_req,
    input  logic [COORD_W-1:0] eng_x,
    input  logic [COORD_W-1:0] eng_y,
    output logic               eng_gnt,
    output logic [1:0]         eng_rdata,
    output logic               eng_rvalid,
    input  logic               bfs_req,
    input  logic [COORD_W-1:0] bfs_x,
    input  logic [COORD_W-1:0] bfs_y,
    output logic               bfs_gnt,
    output logic [1:0]         bfs_rdata,
    output logic               bfs_rvalid,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_re,
    output logic               ram_we,
    output logic [1:0]         ram_wdata,
    input  logic [1:0]         ram_rdata,
    output logic [CNT_W-1:0]   ships_left,
    output logic               mem_empty,
    output logic               busy
);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    logic              in_range_q, in_range_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [1:0]        ram_wdata_q, ram_wdata_d;
    logic              init_gnt_q, init_gnt_d;
    logic              eng_gnt_q, eng_gnt_d;
    logic              bfs_gnt_q, bfs_gnt_d;
    logic              eng_rvalid_q, eng_rvalid_d;
    logic              bfs_rvalid_q, bfs_rvalid_d;
    logic [1:0]        eng_rdata_q, eng_rdata_d;
    logic [1:0]        bfs_rdata_q, bfs_rdata_d;
    logic [CNT_W-1:0]  ships_q, ships_d;
    logic              mem_empty_q, mem_empty_d;
    logic              busy_q, busy_d;

    logic               arb_en_s;
    logic               eng_win_s;
    logic               bfs_win_s;
    logic [COORD_W-1:0] sel_x_s;
    logic [COORD_W-1:0] sel_y_s;
    logic               init_ok_s;
    logic [1:0]         cap_data_s;

    board_rr_arb u_rr_arb (
        .clk       (clk),
        .rstn      (rstn),
        .eng_req_i (eng_req),
        .bfs_req_i (bfs_req),
        .en_i      (arb_en_s),
        .eng_win_o (eng_win_s),
        .bfs_win_o (bfs_win_s)
    );

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        in_range_d   = in_range_q;
        ram_addr_d   = ram_addr_q;
        ram_re_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        init_gnt_d   = 1'b0;
        eng_gnt_d    = 1'b0;
        bfs_gnt_d    = 1'b0;
        eng_rvalid_d = 1'b0;
        bfs_rvalid_d = 1'b0;
        eng_rdata_d  = eng_rdata_q;
        bfs_rdata_d  = bfs_rdata_q;
        ships_d      = ships_q;
        arb_en_s     = 1'b0;
        sel_x_s      = eng_win_s ? eng_x : bfs_x;
        sel_y_s      = eng_win_s ? eng_y : bfs_y;
        init_ok_s    = cell_in_range(init_x, init_y);
        cap_data_s   = in_range_q ? ram_rdata : CELL_EMPTY;

        if (clear) begin
            // Entered (or restarted) from any state; aborts an in-flight access.
            state_d     = ST_CLEAR;
            ram_addr_d  = {ADDR_W{1'b0}};
            ram_we_d    = 1'b1;
            ram_wdata_d = CELL_EMPTY;
            ships_d     = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A granted loader still holds req during the gnt cycle.
                    if (init_req && !init_gnt_q) begin
                        init_gnt_d  = 1'b1;
                        ram_we_d    = init_ok_s;
                        ram_addr_d  = cell_addr(init_x, init_y);
                        ram_wdata_d = init_data;
                        if (init_ok_s && (init_data == CELL_SHIP) && (ships_q != CELLS_CNT)) begin
                            ships_d = ships_q + CNT_W'(1);
                        end else begin
                            ships_d = ships_q;
                        end
                    end else if (eng_req || bfs_req) begin
                        arb_en_s   = 1'b1;
                        owner_d    = eng_win_s ? REQ_ENG : REQ_BFS;
                        eng_gnt_d  = eng_win_s;
                        bfs_gnt_d  = bfs_win_s;
                        in_range_d = cell_in_range(sel_x_s, sel_y_s);
                        ram_re_d   = cell_in_range(sel_x_s, sel_y_s);
                        ram_addr_d = cell_addr(sel_x_s, sel_y_s);
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_d = ST_IDLE;
                    if (owner_q == REQ_ENG) begin
                        eng_rvalid_d = 1'b1;
                        eng_rdata_d  = cap_data_s;
                        if (cap_data_s == CELL_SHIP) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = CELL_HIT;
                            ships_d     = (ships_q != {CNT_W{1'b0}}) ? ships_q - CNT_W'(1) : ships_q;
                        end else begin
                            ram_we_d = 1'b0;
                        end
                    end else begin
                        bfs_rvalid_d = 1'b1;
                        bfs_rdata_d  = cap_data_s;
                    end
                end
                ST_CLEAR: begin
                    if (ram_addr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        ram_addr_d  = ram_addr_q + ADDR_W'(1);
                        ram_we_d    = 1'b1;
                        ram_wdata_d = CELL_EMPTY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        mem_empty_d = (ships_d == {CNT_W{1'b0}}) && (state_d != ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_ENG;
            in_range_q   <= 1'b0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            ram_re_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 2'b00;
            init_gnt_q   <= 1'b0;
            eng_gnt_q    <= 1'b0;
            bfs_gnt_q    <= 1'b0;
            eng_rvalid_q <= 1'b0;
            bfs_rvalid_q <= 1'b0;
            eng_rdata_q  <= 2'b00;
            bfs_rdata_q  <= 2'b00;
            ships_q      <= {CNT_W{1'b0}};
            mem_empty_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            in_range_q   <= in_range_d;
            ram_addr_q   <= ram_addr_d;
            ram_re_q     <= ram_re_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            init_gnt_q   <= init_gnt_d;
            eng_gnt_q    <= eng_gnt_d;
            bfs_gnt_q    <= bfs_gnt_d;
            eng_rvalid_q <= eng_rvalid_d;
            bfs_rvalid_q <= bfs_rvalid_d;
            eng_rdata_q  <= eng_rdata_d;
            bfs_rdata_q  <= bfs_rdata_d;
            ships_q      <= ships_d;
            mem_empty_q  <= mem_empty_d;
            busy_q       <= busy_d;
        end
    end

    assign init_gnt   = init_gnt_q;
    assign eng_gnt    = eng_gnt_q;
    assign bfs_gnt    = bfs_gnt_q;
    assign eng_rvalid = eng_rvalid_q;
    assign bfs_rvalid = bfs_rvalid_q;
    assign eng_rdata  = eng_rdata_q;
    assign bfs_rdata  = bfs_rdata_q;
    assign ram_addr   = ram_addr_q;
    assign ram_re     = ram_re_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign ships_left = ships_q;
    assign mem_empty  = mem_empty_q;
    assign busy       = busy_q;

endmodule
